// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl_if
// Description : Bundle of signals between the fetch controller and its
//               neighbours. It covers the instruction-memory req/gnt/rvalid
//               bus, the redirect input from execute, and the valid/ready
//               hand-off to decode.
//               master = fetch controller side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if;
  // instruction-memory bus
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // redirect from execute
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // decode hand-off
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  // status
  logic        fetch_misaligned;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output if_valid, if_pc, if_instr,
    input  if_ready,
    output fetch_misaligned
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  if_valid, if_pc, if_instr,
    output if_ready,
    input  fetch_misaligned
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Owns the architectural PC. Issues one instruction-memory
//               request at a time and presents {pc, instr} to decode. The PC
//               advances by 4 on consumption or loads a redirect target.
//               A redirect that leaves a response in flight parks the FSM in
//               DROP until that stale response has been absorbed.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_ctrl_if.master  bus
);

  // Word alignment is forced so imem_addr[1:0] can never be non-zero.
  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        mis_q, mis_d;
  logic [31:0] w_redir_tgt;

  assign w_redir_tgt = {bus.redirect_pc[31:2], 2'b00};

  // State and datapath registers; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= c_reset_pc;
      if_pc_q    <= c_reset_pc;
      if_instr_q <= 32'h0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      mis_q      <= mis_d;
    end
  end

  // Next-state logic. A redirect outranks every other transition and
  // always reloads the PC, whatever the state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    mis_d      = mis_q;

    if (bus.redirect_valid) begin
      pc_d = w_redir_tgt;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.redirect_valid) begin
          // An accepted request means a response is already on its way.
          state_d = bus.imem_gnt ? S_DROP : S_REQ;
        end else if (bus.imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          state_d = bus.imem_rvalid ? S_REQ : S_DROP;
        end else if (bus.imem_rvalid) begin
          if_instr_d = bus.imem_rdata;
          if_pc_d    = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          // A transfer in the same cycle still happens, but the PC takes
          // the redirect target rather than pc+4.
          state_d = S_REQ;
        end else if (bus.if_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req         = (state_q == S_REQ);
  assign bus.imem_addr        = pc_q;
  assign bus.if_valid         = (state_q == S_HOLD);
  assign bus.if_pc            = if_pc_q;
  assign bus.if_instr         = if_instr_q;
  assign bus.fetch_misaligned = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Cycle-accurate vector bench for pc_fetch_ctrl. Each record
//               holds the inputs for one cycle and the expected outputs in
//               that cycle, sampled before the rising edge. if_pc/if_instr
//               are only compared while if_valid is expected high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  typedef struct {
    int          tag;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  vec_t vecs[$];
  vec_t post[$];

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(
    input int tag, input logic gnt, input logic rv, input logic [31:0] rdata,
    input logic rd, input logic [31:0] rpc, input logic rdy,
    input logic ereq, input logic [31:0] eaddr, input logic ev,
    input logic [31:0] epc, input logic [31:0] einstr, input logic emis);
    vec_t v;
    v.tag = tag; v.gnt = gnt; v.rvalid = rv; v.rdata = rdata;
    v.redir = rd; v.rpc = rpc; v.rdy = rdy;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev;
    v.e_pc = epc; v.e_instr = einstr; v.e_mis = emis;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.imem_gnt       = v.gnt;
    bus.imem_rvalid    = v.rvalid;
    bus.imem_rdata     = v.rdata;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.rpc;
    bus.if_ready       = v.rdy;
  endtask

  task automatic check(input string name, input vec_t v);
    logic ok;
    ok = (bus.imem_req === v.e_req) && (bus.imem_addr === v.e_addr) &&
         (bus.if_valid === v.e_valid) && (bus.fetch_misaligned === v.e_mis);
    if (v.e_valid)
      ok = ok && (bus.if_pc === v.e_pc) && (bus.if_instr === v.e_instr);
    n_total++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL %s tag=%0d got req=%b addr=%h valid=%b pc=%h instr=%h mis=%b want req=%b addr=%h valid=%b pc=%h instr=%h mis=%b",
               name, v.tag, bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_pc,
               bus.if_instr, bus.fetch_misaligned, v.e_req, v.e_addr, v.e_valid,
               v.e_pc, v.e_instr, v.e_mis);
    end
  endtask

  // Reset-value check; if_pc/if_instr are compared unconditionally here.
  task automatic check_reset(input string name);
    n_total++;
    if (bus.imem_req === 1'b0 && bus.imem_addr === 32'h0 && bus.if_valid === 1'b0 &&
        bus.if_pc === 32'h0 && bus.if_instr === 32'h0 && bus.fetch_misaligned === 1'b0) begin
      n_pass++;
    end else begin
      $display("FAIL %s got req=%b addr=%h valid=%b pc=%h instr=%h mis=%b want all zero",
               name, bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_pc,
               bus.if_instr, bus.fetch_misaligned);
    end
  endtask

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;

    //               tag gnt rv rdata          rd rpc            rdy req addr           v  pc             instr          mis
    // basic streaming, rdata=NOP, 3 cycles per instruction
    vecs.push_back(mk( 0, 0, 0, 32'h0,         0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk( 1, 1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk( 2, 0, 1, c_nop,         0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk( 3, 0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         1, 32'h0,         c_nop,         0));
    vecs.push_back(mk( 4, 1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h4,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk( 5, 0, 1, c_nop,         0, 32'h0,         0,  0, 32'h4,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk( 6, 0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h4,         1, 32'h4,         c_nop,         0));
    vecs.push_back(mk( 7, 1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h8,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk( 8, 0, 1, 32'h93,        0, 32'h0,         0,  0, 32'h8,         0, 32'h0,         32'h0,         0));
    // decode stalls 4 cycles in HOLD: outputs stable, no request
    for (int i = 9; i <= 12; i++)
      vecs.push_back(mk(i, 0, 0, 32'h0,        0, 32'h0,         0,  0, 32'h8,         1, 32'h8,         32'h93,        0));
    vecs.push_back(mk(13, 0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h8,         1, 32'h8,         32'h93,        0));
    // no grant for 5 cycles: request and address held
    for (int i = 14; i <= 18; i++)
      vecs.push_back(mk(i, 0, 0, 32'h0,        0, 32'h0,         0,  1, 32'hC,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(19, 1, 0, 32'h0,         0, 32'h0,         0,  1, 32'hC,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(20, 0, 0, 32'h0,         0, 32'h0,         0,  0, 32'hC,         0, 32'h0,         32'h0,         0));
    // redirect to 0x100 in WAIT -> DROP, stale data discarded
    vecs.push_back(mk(21, 0, 0, 32'h0,         1, 32'h100,       0,  0, 32'hC,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(22, 0, 0, 32'h0,         0, 32'h0,         0,  0, 32'h100,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(23, 0, 1, 32'hDEADBEEF,  0, 32'h0,         0,  0, 32'h100,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(24, 1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h100,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(25, 0, 1, 32'h11111111,  0, 32'h0,         0,  0, 32'h100,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(26, 0, 0, 32'h0,         0, 32'h0,         0,  0, 32'h100,       1, 32'h100,       32'h11111111,  0));
    // redirect to 0x200 in HOLD with if_ready=1: transfer, pc = target
    vecs.push_back(mk(27, 0, 0, 32'h0,         1, 32'h200,       1,  0, 32'h100,       1, 32'h100,       32'h11111111,  0));
    vecs.push_back(mk(28, 0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h200,       0, 32'h0,         32'h0,         0));
    // retraction in REQ to 0xFFFF_FFFC, then wrap to 0 on consumption
    vecs.push_back(mk(29, 0, 0, 32'h0,         1, 32'hFFFFFFFC,  0,  1, 32'h200,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(30, 1, 0, 32'h0,         0, 32'h0,         0,  1, 32'hFFFFFFFC,  0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(31, 0, 1, 32'h22222222,  0, 32'h0,         0,  0, 32'hFFFFFFFC,  0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(32, 0, 0, 32'h0,         0, 32'h0,         1,  0, 32'hFFFFFFFC,  1, 32'hFFFFFFFC,  32'h22222222,  0));
    // redirect with gnt in same cycle -> DROP; second redirect in DROP
    vecs.push_back(mk(33, 1, 0, 32'h0,         1, 32'h300,       0,  1, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(34, 0, 0, 32'h0,         1, 32'h400,       0,  0, 32'h300,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(35, 0, 1, 32'h44444444,  0, 32'h0,         0,  0, 32'h400,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(36, 1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h400,       0, 32'h0,         32'h0,         0));
    // redirect in WAIT with rvalid same cycle -> straight back to REQ
    vecs.push_back(mk(37, 0, 1, 32'h33333333,  1, 32'h500,       0,  0, 32'h400,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(38, 0, 0, 32'h0,         0, 32'h0,         0,  1, 32'h500,       0, 32'h0,         32'h0,         0));
    // misaligned redirect 0x103 -> addr 0x100, sticky flag
    vecs.push_back(mk(39, 0, 0, 32'h0,         1, 32'h103,       0,  1, 32'h500,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(40, 1, 0, 32'h0,         0, 32'h0,         0,  1, 32'h100,       0, 32'h0,         32'h0,         1));
    vecs.push_back(mk(41, 0, 0, 32'h0,         0, 32'h0,         0,  0, 32'h100,       0, 32'h0,         32'h0,         1));

    // after mid-WAIT reset: rvalid in IDLE/REQ ignored, then a clean fetch
    post.push_back(mk(50, 0, 1, 32'hAAAAAAAA,  0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0,         0));
    post.push_back(mk(51, 0, 1, 32'hAAAAAAAA,  0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         32'h0,         0));
    post.push_back(mk(52, 1, 1, 32'hAAAAAAAA,  0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         32'h0,         0));
    post.push_back(mk(53, 0, 1, 32'h55555555,  0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0,         0));
    post.push_back(mk(54, 0, 0, 32'h0,         0, 32'h0,         0,  0, 32'h0,         1, 32'h0,         32'h55555555,  0));

    // Reset is asserted from time 0 and checked before any clock edge.
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
    #1;
    check_reset("reset_initial");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check("main_vec", vecs[i]);
      @(negedge clk);
    end

    // Asynchronous reset mid-WAIT, asserted between clock edges.
    @(posedge clk);
    drive(mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async_midwait");
    // A late response arriving during reset must not be captured.
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBBBBBBBB;
    @(negedge clk);
    #1;
    check_reset("reset_held_rvalid");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (post[i]) begin
      drive(post[i]);
      #1;
      check("post_reset_vec", post[i]);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
